// File: rtl/hazard_stall_unit.sv
// Load-use hazard stall and taken-branch flush controller with a saturating hazard counter.
// All control outputs are registered and change one cycle after the inputs that cause them.
module hazard_stall_unit #(
    parameter int          LOAD_STALL_CYCLES = 1,
    parameter int          FLUSH_CYCLES      = 2,
    parameter logic [1:0]  SP_REG            = 2'b11,
    parameter int          CNT_W             = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       R_ADD_A_current,
    input  logic [1:0]       R_ADD_B_current,
    input  logic             uses_A,
    input  logic             uses_B,
    input  logic             W_E_R_previous,
    input  logic [1:0]       W_add_previous,
    input  logic [2:0]       w_Data_S_R_previous,
    input  logic             branch_taken,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] hazard_count
);

    localparam int MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    localparam logic [CW-1:0]    STALL_INIT = CW'(LOAD_STALL_CYCLES - 1);
    localparam logic [CW-1:0]    FLUSH_INIT = CW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HZ_MAX     = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pc_we_q, pc_we_d;
    logic             ifid_we_q, ifid_we_d;
    logic             bubble_q, bubble_d;
    logic             flush_q, flush_d;
    logic             stall_act_q, stall_act_d;
    logic [CNT_W-1:0] hz_cnt_q, hz_cnt_d;
    logic             load_hz;

    // Only a Mem-sourced result (select 000) is too late to forward; SP is never hazard-checked.
    always_comb begin
        load_hz = W_E_R_previous && (w_Data_S_R_previous == 3'b000) &&
                  ((uses_A && (R_ADD_A_current != SP_REG) && (R_ADD_A_current == W_add_previous)) ||
                   (uses_B && (R_ADD_B_current != SP_REG) && (R_ADD_B_current == W_add_previous)));
    end

    // Next-state and next-output logic; branch beats load hazard, both beat count-down.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_we_d   = pc_we_q;
        ifid_we_d = ifid_we_q;
        bubble_d  = bubble_q;
        flush_d   = flush_q;
        hz_cnt_d  = hz_cnt_q;
        if (branch_taken) begin
            state_d   = ST_FLUSH;
            cnt_d     = FLUSH_INIT;
            pc_we_d   = 1'b1;
            ifid_we_d = 1'b1;
            bubble_d  = 1'b1;
            flush_d   = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_hz) begin
                        state_d   = ST_STALL;
                        cnt_d     = STALL_INIT;
                        pc_we_d   = 1'b0;
                        ifid_we_d = 1'b0;
                        bubble_d  = 1'b1;
                        flush_d   = 1'b0;
                        if (hz_cnt_q != HZ_MAX) begin
                            hz_cnt_d = hz_cnt_q + CNT_W'(1);
                        end else begin
                            hz_cnt_d = hz_cnt_q;
                        end
                    end else begin
                        state_d   = ST_RUN;
                        pc_we_d   = 1'b1;
                        ifid_we_d = 1'b1;
                        bubble_d  = 1'b0;
                        flush_d   = 1'b0;
                    end
                end
                ST_STALL, ST_FLUSH: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d   = ST_RUN;
                        pc_we_d   = 1'b1;
                        ifid_we_d = 1'b1;
                        bubble_d  = 1'b0;
                        flush_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d   = ST_RUN;
                    cnt_d     = {CW{1'b0}};
                    pc_we_d   = 1'b1;
                    ifid_we_d = 1'b1;
                    bubble_d  = 1'b0;
                    flush_d   = 1'b0;
                end
            endcase
        end
        stall_act_d = (state_d != ST_RUN);
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= {CW{1'b0}};
            pc_we_q     <= 1'b1;
            ifid_we_q   <= 1'b1;
            bubble_q    <= 1'b0;
            flush_q     <= 1'b0;
            stall_act_q <= 1'b0;
            hz_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_we_q     <= pc_we_d;
            ifid_we_q   <= ifid_we_d;
            bubble_q    <= bubble_d;
            flush_q     <= flush_d;
            stall_act_q <= stall_act_d;
            hz_cnt_q    <= hz_cnt_d;
        end
    end

    assign pc_write_en   = pc_we_q;
    assign ifid_write_en = ifid_we_q;
    assign idex_bubble   = bubble_q;
    assign ifid_flush    = flush_q;
    assign stall_active  = stall_act_q;
    assign hazard_count  = hz_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: table of single-cycle stimuli on a default unit, plus hand sequences on a 3-cycle-stall unit.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ra, rb, wadd;
    logic       ua, ub, we, br;
    logic [2:0] sel;

    logic       pc_a, if_a, bub_a, fl_a, sa_a;
    logic [7:0] cnt_a;
    logic       pc_b, if_b, bub_b, fl_b, sa_b;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // {pc_we, ifid_we, idex_bubble, ifid_flush, stall_active}
    localparam logic [4:0] O_NORM  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00101;
    localparam logic [4:0] O_FLUSH = 5'b11111;

    wire [4:0] out_a = {pc_a, if_a, bub_a, fl_a, sa_a};
    wire [4:0] out_b = {pc_b, if_b, bub_b, fl_b, sa_b};

    hazard_stall_unit u_a (
        .clk(clk), .rst(rst),
        .R_ADD_A_current(ra), .R_ADD_B_current(rb), .uses_A(ua), .uses_B(ub),
        .W_E_R_previous(we), .W_add_previous(wadd), .w_Data_S_R_previous(sel),
        .branch_taken(br),
        .pc_write_en(pc_a), .ifid_write_en(if_a), .idex_bubble(bub_a),
        .ifid_flush(fl_a), .stall_active(sa_a), .hazard_count(cnt_a)
    );

    hazard_stall_unit #(.LOAD_STALL_CYCLES(3)) u_b (
        .clk(clk), .rst(rst),
        .R_ADD_A_current(ra), .R_ADD_B_current(rb), .uses_A(ua), .uses_B(ub),
        .W_E_R_previous(we), .W_add_previous(wadd), .w_Data_S_R_previous(sel),
        .branch_taken(br),
        .pc_write_en(pc_b), .ifid_write_en(if_b), .idex_bubble(bub_b),
        .ifid_flush(fl_b), .stall_active(sa_b), .hazard_count(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] ra, rb;
        logic       ua, ub, we;
        logic [1:0] wadd;
        logic [2:0] sel;
        logic       br;
        logic [4:0] exp;
        int         len;
        int         hz;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(string n, logic [1:0] a, logic [1:0] b, logic xa, logic xb,
                                logic w, logic [1:0] d, logic [2:0] s, logic t,
                                logic [4:0] e, int l, int h);
        vec_t v;
        v.name = n; v.ra = a; v.rb = b; v.ua = xa; v.ub = xb; v.we = w;
        v.wadd = d; v.sel = s; v.br = t; v.exp = e; v.len = l; v.hz = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ra = 2'd0; rb = 2'd0; ua = 1'b0; ub = 1'b0; we = 1'b0;
        wadd = 2'd0; sel = 3'd0; br = 1'b0;
    endtask

    task automatic hazard_in();
        ra = 2'd1; rb = 2'd0; ua = 1'b1; ub = 1'b0; we = 1'b1;
        wadd = 2'd1; sel = 3'd0; br = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int exp_cnt;

    initial begin
        rst = 1'b1;
        idle();
        vecs[0]  = mk("hz_A",        2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0, O_STALL, 1, 1);
        vecs[1]  = mk("alu_sel",     2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, O_NORM,  0, 0);
        vecs[2]  = mk("sp_A",        2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0, O_NORM,  0, 0);
        vecs[3]  = mk("no_useA",     2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0, O_NORM,  0, 0);
        vecs[4]  = mk("hz_B",        2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 2'd2, 3'd0, 1'b0, O_STALL, 1, 1);
        vecs[5]  = mk("no_we",       2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0, O_NORM,  0, 0);
        vecs[6]  = mk("in_sel",      2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd3, 1'b0, O_NORM,  0, 0);
        vecs[7]  = mk("imm_sel",     2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd4, 1'b0, O_NORM,  0, 0);
        vecs[8]  = mk("reg_mismatch",2'd0, 2'd2, 1'b1, 1'b1, 1'b1, 2'd1, 3'd0, 1'b0, O_NORM,  0, 0);
        vecs[9]  = mk("branch",      2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, O_FLUSH, 2, 0);
        vecs[10] = mk("branch_hz",   2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 3'd0, 1'b1, O_FLUSH, 2, 0);
        vecs[11] = mk("sp_B",        2'd0, 2'd3, 1'b0, 1'b1, 1'b1, 2'd3, 3'd0, 1'b0, O_NORM,  0, 0);

        step();
        rst = 1'b0;
        chk("reset_out_a", 32'(out_a), 32'(O_NORM));
        chk("reset_cnt_a", 32'(cnt_a), 32'd0);
        chk("reset_out_b", 32'(out_b), 32'(O_NORM));

        // Table: each vector applied for one edge from RUN, then idle until back to normal.
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            ra = vecs[i].ra; rb = vecs[i].rb; ua = vecs[i].ua; ub = vecs[i].ub;
            we = vecs[i].we; wadd = vecs[i].wadd; sel = vecs[i].sel; br = vecs[i].br;
            step();
            idle();
            for (int c = 0; c < vecs[i].len; c++) begin
                chk({vecs[i].name, "_held"}, 32'(out_a), 32'(vecs[i].exp));
                step();
            end
            chk({vecs[i].name, "_after"}, 32'(out_a), 32'(O_NORM));
            exp_cnt += vecs[i].hz;
            chk({vecs[i].name, "_cnt"}, 32'(cnt_a), 32'(exp_cnt));
        end

        // Flush restart: a second branch during FLUSH extends it.
        do_reset();
        br = 1'b1; step();
        chk("flush_restart_1", 32'(out_a), 32'(O_FLUSH));
        step(); idle();
        chk("flush_restart_2", 32'(out_a), 32'(O_FLUSH));
        step();
        chk("flush_restart_3", 32'(out_a), 32'(O_FLUSH));
        step();
        chk("flush_restart_end", 32'(out_a), 32'(O_NORM));

        // Three-cycle stall lasts exactly three cycles.
        do_reset();
        hazard_in(); step(); idle();
        for (int c = 0; c < 3; c++) begin
            chk("stall3_held", 32'(out_b), 32'(O_STALL));
            step();
        end
        chk("stall3_end", 32'(out_b), 32'(O_NORM));
        chk("stall3_cnt", 32'(cnt_b), 32'd1);

        // Branch during STALL abandons the stall and runs a full flush.
        do_reset();
        hazard_in(); step(); idle();
        chk("abort_stall_1", 32'(out_b), 32'(O_STALL));
        step();
        chk("abort_stall_2", 32'(out_b), 32'(O_STALL));
        br = 1'b1; step(); idle();
        chk("abort_flush_1", 32'(out_b), 32'(O_FLUSH));
        step();
        chk("abort_flush_2", 32'(out_b), 32'(O_FLUSH));
        step();
        chk("abort_end", 32'(out_b), 32'(O_NORM));

        // Reset during the second cycle of a stall.
        do_reset();
        hazard_in(); step(); idle();
        step();
        chk("rst_mid_stall_pre", 32'(out_b), 32'(O_STALL));
        chk("rst_mid_cnt_pre", 32'(cnt_b), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_out", 32'(out_b), 32'(O_NORM));
        chk("rst_mid_cnt", 32'(cnt_b), 32'd0);
        step();
        chk("rst_mid_after", 32'(out_b), 32'(O_NORM));

        // Saturation: a held hazard fires every other cycle on the 1-cycle unit.
        do_reset();
        hazard_in();
        for (int c = 0; c < 507; c++) step();
        chk("sat_254", 32'(cnt_a), 32'd254);
        for (int c = 0; c < 800; c++) step();
        chk("sat_a", 32'(cnt_a), 32'd255);
        chk("sat_b", 32'(cnt_b), 32'd255);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
